ps2_mouse_to_host: RTL

- Receiver half of the PS/2 mouse link: device-to-host direction.
- Samples the open-collector ps2_clk / ps2_data lines in the system clock domain. Deframes 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop) and checks them.
- Assembles validated bytes into standard 3-byte mouse movement packets.
- Feeds cursor/blade position logic. Is held off via rx_en while the host-to-mouse transmitter owns the bus.

---
 rtl/ps2_pkg.sv | 35 +++
 rtl/ps2_mouse_to_host_if.sv | 34 +++
 rtl/ps2_line_filter.sv | 65 ++++++
 rtl/ps2_mouse_to_host.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// +----------------------------------------------------------------------+
// | ps2_pkg : shared PS/2 frame and mouse packet definitions             |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int SYNC_BIT = 3;
  localparam int XSIGN    = 4;
  localparam int YSIGN    = 5;
  localparam int XOVF     = 6;
  localparam int YOVF     = 7;

  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic frame_ok(input logic [7:0] data, input logic parity,
                                    input logic stop);
    return (stop == STOP_BIT) && (^{data, parity});
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_mouse_to_host_if.sv
// +----------------------------------------------------------------------+
// | ps2_mouse_to_host_if : PS/2 receive-side lines and decoded outputs   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface ps2_mouse_to_host_if;
  logic       rx_en;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       frame_err;
  logic       pkt_valid;
  logic [2:0] pkt_buttons;
  logic [8:0] pkt_dx;
  logic [8:0] pkt_dy;
  logic [1:0] pkt_ovf;

  modport master (
    output rx_en, ps2_clk, ps2_data,
    input  rx_byte, rx_byte_valid, frame_err,
    input  pkt_valid, pkt_buttons, pkt_dx, pkt_dy, pkt_ovf
  );

  modport slave (
    input  rx_en, ps2_clk, ps2_data,
    output rx_byte, rx_byte_valid, frame_err,
    output pkt_valid, pkt_buttons, pkt_dx, pkt_dy, pkt_ovf
  );
endinterface

`default_nettype wire

// File: rtl/ps2_line_filter.sv
// +----------------------------------------------------------------------+
// | ps2_line_filter : synchronise PS/2 lines, debounce clock, fall strobe|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_fall_o,
  output logic data_sync_o
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic [1:0]       clk_sync_q;
  logic [1:0]       data_sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fall_q, fall_d;

  // Count consecutive samples disagreeing with the filtered level.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    fall_d  = 1'b0;
    if (clk_sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
      level_d = clk_sync_q[1];
      cnt_d   = '0;
      fall_d  = level_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Idle-high reset values keep the first real edge from looking like a glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      level_q     <= 1'b1;
      cnt_q       <= '0;
      fall_q      <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      fall_q      <= fall_d;
    end
  end

  assign clk_fall_o  = fall_q;
  assign data_sync_o = data_sync_q[1];

endmodule

`default_nettype wire

// File: rtl/ps2_mouse_to_host.sv
// +----------------------------------------------------------------------+
// | ps2_mouse_to_host : PS/2 device-to-host deframer and packet builder  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module ps2_mouse_to_host
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                clk,
  input  logic                rst,
  ps2_mouse_to_host_if.slave  bus
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic w_fall;
  logic w_data;
  logic w_timeout;

  ps2_state_e       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [1:0]       pkt_idx_q, pkt_idx_d;
  logic [7:0]       byte0_q, byte0_d;
  logic [7:0]       byte1_q, byte1_d;
  logic             pkt_valid_q, pkt_valid_d;
  logic [2:0]       buttons_q, buttons_d;
  logic [8:0]       dx_q, dx_d;
  logic [8:0]       dy_q, dy_d;
  logic [1:0]       ovf_q, ovf_d;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_i   (bus.ps2_clk),
    .ps2_data_i  (bus.ps2_data),
    .clk_fall_o  (w_fall),
    .data_sync_o (w_data)
  );

  assign w_timeout = (state_q != IDLE) && (tmo_q == TMO_W'(TIMEOUT_CYC));

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    tmo_d       = tmo_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    pkt_idx_d   = pkt_idx_q;
    byte0_d     = byte0_q;
    byte1_d     = byte1_q;
    pkt_valid_d = 1'b0;
    buttons_d   = buttons_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    ovf_d       = ovf_q;

    if (!bus.rx_en) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      pkt_idx_d = '0;
      tmo_d     = '0;
    end else begin
      tmo_d = (state_q == IDLE || w_fall) ? '0 : tmo_q + 1'b1;

      // A timeout takes priority over a fall landing in the same cycle.
      if (w_timeout) begin
        frame_err_d = 1'b1;
        state_d     = IDLE;
        bit_cnt_d   = '0;
        tmo_d       = '0;
      end else if (w_fall) begin
        unique case (state_q)
          IDLE: begin
            if (w_data == START_BIT) begin
              state_d   = DATA;
              bit_cnt_d = '0;
            end else begin
              frame_err_d = 1'b1;
            end
          end
          DATA: begin
            shift_d[bit_cnt_q] = w_data;
            bit_cnt_d          = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = PARITY;
          end
          PARITY: begin
            parity_d = w_data;
            state_d  = STOP;
          end
          STOP: begin
            state_d = IDLE;
            if (frame_ok(shift_q, parity_q, w_data)) begin
              rx_byte_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end

      if (frame_err_d) begin
        pkt_idx_d = '0;
      end else if (rx_valid_q) begin
        unique case (pkt_idx_q)
          2'd0: begin
            if (rx_byte_q[SYNC_BIT]) begin
              byte0_d   = rx_byte_q;
              pkt_idx_d = 2'd1;
            end
          end
          2'd1: begin
            byte1_d   = rx_byte_q;
            pkt_idx_d = 2'd2;
          end
          default: begin
            buttons_d   = byte0_q[2:0];
            dx_d        = {byte0_q[XSIGN], byte1_q};
            dy_d        = {byte0_q[YSIGN], rx_byte_q};
            ovf_d       = {byte0_q[YOVF], byte0_q[XOVF]};
            pkt_valid_d = 1'b1;
            pkt_idx_d   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      pkt_idx_q   <= '0;
      byte0_q     <= '0;
      byte1_q     <= '0;
      pkt_valid_q <= 1'b0;
      buttons_q   <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      ovf_q       <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      pkt_idx_q   <= pkt_idx_d;
      byte0_q     <= byte0_d;
      byte1_q     <= byte1_d;
      pkt_valid_q <= pkt_valid_d;
      buttons_q   <= buttons_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.rx_byte       = rx_byte_q;
  assign bus.rx_byte_valid = rx_valid_q;
  assign bus.frame_err     = frame_err_q;
  assign bus.pkt_valid     = pkt_valid_q;
  assign bus.pkt_buttons   = buttons_q;
  assign bus.pkt_dx        = dx_q;
  assign bus.pkt_dy        = dy_q;
  assign bus.pkt_ovf       = ovf_q;

endmodule

`default_nettype wire
